// File: rtl/cla_mul_sequencer.sv
// Multi-cycle unsigned 16x16 shift-and-add multiplier (low 16 product bits).
// One 16-bit carry-lookahead adder is reused once per iteration.

module cla4_block (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_g,
  output logic       o_p
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum = w_p ^ w_c;
  assign o_g   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign o_p   = &w_p;
endmodule

module alt_CLA_4_4_4_4_adder (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);
  logic [3:0] w_gg;
  logic [3:0] w_gp;
  logic [3:0] w_gc;

  // Second-level lookahead: group carries come straight from group generate/propagate.
  assign w_gc[0] = i_cin;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & i_cin);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
  assign o_cout  = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_cin);

  for (genvar gi = 0; gi < 4; gi++) begin : g_blk
    cla4_block u_blk (
      .i_a   (i_a[4*gi +: 4]),
      .i_b   (i_b[4*gi +: 4]),
      .i_cin (w_gc[gi]),
      .o_sum (o_sum[4*gi +: 4]),
      .o_g   (w_gg[gi]),
      .o_p   (w_gp[gi])
    );
  end
endmodule

module cla_mul_sequencer #(
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_result
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [15:0] r_mcand;
  logic [15:0] r_mplier;
  logic [15:0] r_acc;
  logic [3:0]  r_count;
  logic [15:0] r_result;

  logic [15:0] w_sum;
  logic        w_unused_cout;
  logic [15:0] w_acc_next;
  logic        w_last;

  alt_CLA_4_4_4_4_adder u_adder (
    .i_a    (r_acc),
    .i_b    (r_mcand),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_unused_cout)
  );

  assign w_acc_next = r_mplier[0] ? w_sum : r_acc;
  // Early exit looks at the multiplier as it will be after this edge's shift.
  assign w_last     = (r_count == 4'd15) ||
                      (EARLY_EXIT && (r_mplier[15:1] == 15'd0));

  // Control FSM and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_mcand  <= 16'h0000;
      r_mplier <= 16'h0000;
      r_acc    <= 16'h0000;
      r_count  <= 4'd0;
      r_result <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= 16'h0000;
            r_count  <= 4'd0;
            r_state  <= S_RUN;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= {r_mcand[14:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[15:1]};
          r_count  <= r_count + 4'd1;
          if (w_last) begin
            r_result <= w_acc_next;
            r_state  <= S_DONE;
          end else begin
            r_state  <= S_RUN;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy   = (r_state == S_RUN);
  assign o_done   = (r_state == S_DONE);
  assign o_result = r_result;
endmodule

// File: tb/tb_cla_mul_sequencer.sv
// Scoreboard bench for cla_mul_sequencer: one instance with EARLY_EXIT=0, one with EARLY_EXIT=1.
module tb_cla_mul_sequencer;
  logic        clk = 1'b0;
  logic [1:0]  rst_v;
  logic [1:0]  start_v;
  logic [15:0] a_v [2];
  logic [15:0] b_v [2];
  wire         busy0, busy1, done0, done1;
  wire  [15:0] res0, res1;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt [2];
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic [15:0] e0, e1;

  always #5 clk = ~clk;

  cla_mul_sequencer #(.EARLY_EXIT(1'b0)) u_dut0 (
    .i_clk(clk), .i_reset(rst_v[0]), .i_start(start_v[0]), .i_a(a_v[0]), .i_b(b_v[0]),
    .o_busy(busy0), .o_done(done0), .o_result(res0));

  cla_mul_sequencer #(.EARLY_EXIT(1'b1)) u_dut1 (
    .i_clk(clk), .i_reset(rst_v[1]), .i_start(start_v[1]), .i_a(a_v[1]), .i_b(b_v[1]),
    .o_busy(busy1), .o_done(done1), .o_result(res1));

  function automatic logic bz(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction
  function automatic logic dn(input int d);
    return (d == 0) ? done0 : done1;
  endfunction
  function automatic logic [15:0] rs(input int d);
    return (d == 0) ? res0 : res1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [15:0] e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      done_cnt[0]++;
      if (q0.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL dut0_unexpected_done: got done=1 with result 0x%0h, expected no pulse", res0);
      end else begin
        e0 = q0.pop_front();
        chk("dut0_result", {16'h0, res0}, {16'h0, e0});
      end
    end
    if (done1 === 1'b1) begin
      done_cnt[1]++;
      if (q1.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL dut1_unexpected_done: got done=1 with result 0x%0h, expected no pulse", res1);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_result", {16'h0, res1}, {16'h0, e1});
      end
    end
  end

  // Issue one op, optionally poke start mid-run at cycle 'inject', then check timing and hold.
  task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] e, input int lat, input int inject);
    int cyc;
    int bcnt;
    @(negedge clk);
    start_v[d] = 1'b1; a_v[d] = a; b_v[d] = b;
    push(d, e);
    @(negedge clk);
    start_v[d] = 1'b0;
    cyc = 1; bcnt = 0;
    while (!dn(d) && cyc < 40) begin
      if (bz(d)) bcnt++;
      if (cyc == inject) begin
        start_v[d] = 1'b1; a_v[d] = 16'd7; b_v[d] = 16'd9;
      end else begin
        start_v[d] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start_v[d] = 1'b0;
    chk($sformatf("d%0d_latency_%0h_x_%0h", d, a, b), cyc, lat);
    chk($sformatf("d%0d_busy_cycles_%0h_x_%0h", d, a, b), bcnt, lat - 1);
    @(negedge clk);
    chk($sformatf("d%0d_result_hold", d), {16'h0, rs(d)}, {16'h0, e});
    chk($sformatf("d%0d_done_falls", d), {31'h0, dn(d)}, 32'h0);
  endtask

  initial begin
    int dc;
    int cyc;
    int gap;
    done_cnt[0] = 0; done_cnt[1] = 0;
    rst_v = 2'b11; start_v = 2'b00;
    a_v[0] = 16'h0; a_v[1] = 16'h0; b_v[0] = 16'h0; b_v[1] = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset_busy0", {31'h0, busy0}, 32'h0);
    chk("reset_done0", {31'h0, done0}, 32'h0);
    chk("reset_result0", {16'h0, res0}, 32'h0);
    chk("reset_busy1", {31'h0, busy1}, 32'h0);
    chk("reset_result1", {16'h0, res1}, 32'h0);
    rst_v = 2'b00;

    // Basic and wrap-around products, full 16-iteration latency.
    run_op(0, 16'd3, 16'd5, 16'h000F, 17, 0);
    run_op(0, 16'hFFFF, 16'hFFFF, 16'h0001, 17, 0);
    run_op(0, 16'h0100, 16'h0100, 16'h0000, 17, 0);
    run_op(0, 16'h1234, 16'h0010, 16'h2340, 17, 0);

    // start during RUN is ignored.
    dc = done_cnt[0];
    run_op(0, 16'd3, 16'd5, 16'h000F, 17, 5);
    repeat (3) @(negedge clk);
    chk("ignored_start_one_done", done_cnt[0] - dc, 1);

    // Reset in the middle of a run abandons it silently.
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 16'd3; b_v[0] = 16'd5;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (7) @(negedge clk);
    chk("busy_before_reset", {31'h0, busy0}, 32'h1);
    rst_v[0] = 1'b1;
    @(negedge clk);
    chk("midrun_reset_busy", {31'h0, busy0}, 32'h0);
    chk("midrun_reset_done", {31'h0, done0}, 32'h0);
    chk("midrun_reset_result", {16'h0, res0}, 32'h0);
    rst_v[0] = 1'b0;
    dc = done_cnt[0];
    repeat (20) @(negedge clk);
    chk("no_done_after_reset", done_cnt[0] - dc, 0);
    run_op(0, 16'd2, 16'd2, 16'h0004, 17, 0);

    // Back-to-back: start held through DONE launches the next op immediately.
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 16'd3; b_v[0] = 16'd5;
    push(0, 16'h000F);
    push(0, 16'h002A);
    @(negedge clk);
    a_v[0] = 16'd6; b_v[0] = 16'd7;
    cyc = 1;
    while (!done0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_first_latency", cyc, 17);
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("b2b_no_idle_gap", {31'h0, busy0}, 32'h1);
    gap = 1;
    while (!done0 && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b_done_spacing", gap, 17);
    @(negedge clk);
    chk("b2b_result_hold", {16'h0, res0}, 32'h002A);

    // Early-exit instance.
    run_op(1, 16'hABCD, 16'h0001, 16'hABCD, 2, 0);
    run_op(1, 16'd5, 16'h0004, 16'h0014, 4, 0);
    run_op(1, 16'h1234, 16'h0000, 16'h0000, 2, 0);

    repeat (5) @(negedge clk);
    chk("dut0_queue_drained", q0.size(), 0);
    chk("dut1_queue_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cla_mul_sequencer.md
Name: cla_mul_sequencer

Overview:
- Multi-cycle unsigned 16x16 shift-and-add multiplier controller.
- Returns the low 16 bits of the product (mod 2^16).
- Sequences one instance of the team's 16-bit carry-lookahead adder (alt_CLA_4_4_4_4_adder, cin tied 0) as its only arithmetic resource.
- Sits beside the ALU as the MUL execution unit, with a start/busy/done handshake to the CPU control unit.

Parameters:
- EARLY_EXIT, 0, when 1 the sequence finishes as soon as the remaining multiplier bits are all zero; when 0 it always runs 16 iterations.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE or DONE.
- a  input  16  multiplicand; captured on an accepted start.
- b  input  16  multiplier; captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- result  output  16  low 16 bits of a*b; holds until the next completion or reset.

Behaviour:
- Registers:
  - mcand[15:0], mplier[15:0], acc[15:0], count[3:0]
  - state: IDLE, RUN, DONE
  - result_q[15:0]
- Adder hookup: A=acc, B=mcand, cin=0; sum feeds acc. No carry-out is used; overflow past bit 15 is discarded by design.
- Reset (synchronous, wins over everything):
  - state=IDLE; busy=0, done=0, result=0x0000
  - acc, mcand, mplier, count cleared
  - Applies identically mid-RUN: the in-flight operation is abandoned with no done pulse.
- IDLE:
  - start=1 → mcand=a, mplier=b, acc=0, count=0, next=RUN.
  - start=0 → stay IDLE.
- RUN, each edge performs one iteration:
  - If mplier[0]=1: acc ← adder sum. Otherwise acc unchanged.
  - mcand ← mcand<<1; mplier ← mplier>>1; count ← count+1.
  - Next=DONE if count==15, or if EARLY_EXIT=1 and (mplier>>1)==0. Otherwise stay RUN.
  - On the transition to DONE, result_q ← the final acc value, including the add performed on that edge.
- DONE (lasts exactly one cycle):
  - done=1, busy=0.
  - start=1 → accepted exactly as in IDLE (back-to-back operation), next=RUN.
  - start=0 → next=IDLE.
- start while in RUN is ignored: no capture, no queueing. a and b may change freely after capture.
- Latency, with start accepted at edge E0:
  - EARLY_EXIT=0: busy=1 from after E0 until edge E0+16; done=1 in the cycle after E0+16.
  - EARLY_EXIT=1: done follows the iteration that empties mplier. Minimum latency is one RUN cycle (b=0 or b=1 → done in the cycle after E0+1).
- Outputs:
  - busy = (state==RUN); done = (state==DONE); both are decoded from registered state.
  - result is driven from result_q only, so it never shows partial sums.

Test Plan:
1. Reset, then start with a=3, b=5 (EARLY_EXIT=0) → busy high 16 cycles; done pulses once in the cycle after E0+16; result=0x000F and holds after done falls.
2. a=0xFFFF, b=0xFFFF → result=0x0001 (wrap-around); a=0x0100, b=0x0100 → result=0x0000; a=0x1234, b=0x0010 → result=0x2340.
3. Assert start with a=7, b=9 while busy mid-run of 3*5 → ignored; result=0x000F; exactly one done pulse.
4. Assert reset at RUN iteration 8 of 3*5 → next cycle busy=0, done=0, result=0x0000, state IDLE; done never pulses; a new start with 2*2 completes with result=0x0004.
5. Hold start high through the DONE cycle with new a=6, b=7 → second op starts without an IDLE cycle; result=0x002A; two done pulses 17 cycles apart.
6. EARLY_EXIT=1:
   - b=1, a=0xABCD → done in the cycle after E0+1, result=0xABCD.
   - b=0x0004, a=5 → done after 3 RUN cycles, result=0x0014.
   - b=0 → result=0x0000 after 1 RUN cycle.
